// File: rtl/cast_pkg.sv
// Shared fixed-point cast definitions: rounding mode selector used by requantizers.
package cast_pkg;

    typedef enum logic {
        ROUND_FLOOR   = 1'b0,
        ROUND_HALF_UP = 1'b1
    } round_mode_t;

endpackage

// File: rtl/signed_clamp.sv
// Combinational signed saturation from IN_WIDTH to OUT_WIDTH; zero latency, no flow control.
// sat flags that the clamp altered the value.
module signed_clamp #(
    parameter int IN_WIDTH  = 17,
    parameter int OUT_WIDTH = 8,
    parameter bit SYMMETRIC = 1'b0
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        sat
);

    localparam logic signed [IN_WIDTH-1:0] MAX_V =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH-1:0] MIN_FULL =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    // Symmetric range drops the most negative code so |min| == max.
    localparam logic signed [IN_WIDTH-1:0] MIN_V =
        SYMMETRIC ? MIN_FULL + IN_WIDTH'(1) : MIN_FULL;

    always_comb begin
        dout = din[OUT_WIDTH-1:0];
        sat  = 1'b0;
        if (din > MAX_V) begin
            dout = MAX_V[OUT_WIDTH-1:0];
            sat  = 1'b1;
        end else if (din < MIN_V) begin
            dout = MIN_V[OUT_WIDTH-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fixed_requant_stream.sv
// Streaming requantizer: round/shift then clamp, 2-cycle latency, 1 sample/cycle.
// Valid/ready backpressure; data_in_ready is combinational from data_out_ready.
module fixed_requant_stream
    import cast_pkg::*;
#(
    parameter int          IN_WIDTH   = 16,
    parameter int          OUT_WIDTH  = 8,
    parameter int          SHIFT      = 4,
    parameter round_mode_t ROUND_MODE = ROUND_HALF_UP,
    parameter bit          SYMMETRIC  = 1'b0,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  data_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        data_out_valid,
    input  logic                        data_out_ready,
    output logic [CNT_WIDTH-1:0]        sat_count,
    input  logic                        sat_count_clear
);

    // One guard bit so the half-LSB bias cannot overflow at the positive rail.
    localparam int RW = IN_WIDTH + 1;

    logic signed [RW-1:0]        in_ext;
    logic signed [RW-1:0]        rounded;
    logic signed [RW-1:0]        s1_data;
    logic                        s1_valid;
    logic                        s1_load;
    logic                        s2_load;
    logic                        s2_sat;
    logic signed [OUT_WIDTH-1:0] clamp_out;
    logic                        clamp_sat;

    assign in_ext = {data_in[IN_WIDTH-1], data_in};

    if (SHIFT == 0) begin : g_bypass
        assign rounded = in_ext;
    end else if (ROUND_MODE == ROUND_HALF_UP) begin : g_half_up
        localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (SHIFT-1);
        logic signed [RW-1:0] biased;
        assign biased  = in_ext + HALF;
        assign rounded = biased >>> SHIFT;
    end else begin : g_floor
        assign rounded = in_ext >>> SHIFT;
    end

    assign s2_load       = !data_out_valid || data_out_ready;
    assign s1_load       = !s1_valid || s2_load;
    assign data_in_ready = s1_load;

    signed_clamp #(
        .IN_WIDTH  (RW),
        .OUT_WIDTH (OUT_WIDTH),
        .SYMMETRIC (SYMMETRIC)
    ) u_clamp (
        .din  (s1_data),
        .dout (clamp_out),
        .sat  (clamp_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_data        <= '0;
            data_out_valid <= 1'b0;
            data_out       <= '0;
            s2_sat         <= 1'b0;
            sat_count      <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= data_in_valid;
                if (data_in_valid) begin
                    s1_data <= rounded;
                end
            end
            if (s2_load) begin
                data_out_valid <= s1_valid;
                if (s1_valid) begin
                    data_out <= clamp_out;
                    s2_sat   <= clamp_sat;
                end
            end
            // Clear wins over a same-cycle increment; counter sticks at all-ones.
            if (sat_count_clear) begin
                sat_count <= '0;
            end else if (data_out_valid && data_out_ready && s2_sat && !(&sat_count)) begin
                sat_count <= sat_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fixed_requant_stream.sv
// Scoreboard bench for fixed_requant_stream: default, symmetric and 2-bit-counter instances share stimulus.
module tb_fixed_requant_stream;
    import cast_pkg::*;

    typedef struct {
        int def;
        int sym;
        bit sd;
        bit ss;
        int cyc;
    } exp_t;

    typedef struct {
        int v;
        int ed;
        int es;
        bit sd;
        bit ss;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] data_in = '0;
    logic               data_in_valid = 1'b0;
    logic               data_out_ready = 1'b1;
    logic               sat_count_clear = 1'b0;

    logic               in_rdy, in_rdy_sym, in_rdy_c2;
    logic signed [7:0]  dout, dout_sym, dout_c2;
    logic               dvld, dvld_sym, dvld_c2;
    logic [15:0]        sat_count, sat_count_sym;
    logic [1:0]         sat_count_c2;

    exp_t q[$];
    exp_t me;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_pop = 0;
    int   cnt_def = 0, cnt_sym = 0, cnt_c2 = 0;
    bit   mon_en = 1'b0, lat_chk = 1'b0, hold_prev = 1'b0, rand_on = 1'b0;
    bit   s_d, s_s;
    logic signed [7:0] prev_dat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fixed_requant_stream #(
        .IN_WIDTH(16), .OUT_WIDTH(8), .SHIFT(4), .ROUND_MODE(ROUND_HALF_UP),
        .SYMMETRIC(1'b0), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(in_rdy), .data_out(dout), .data_out_valid(dvld),
        .data_out_ready(data_out_ready), .sat_count(sat_count), .sat_count_clear(sat_count_clear)
    );

    fixed_requant_stream #(
        .IN_WIDTH(16), .OUT_WIDTH(8), .SHIFT(4), .ROUND_MODE(ROUND_HALF_UP),
        .SYMMETRIC(1'b1), .CNT_WIDTH(16)
    ) dut_sym (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(in_rdy_sym), .data_out(dout_sym), .data_out_valid(dvld_sym),
        .data_out_ready(data_out_ready), .sat_count(sat_count_sym), .sat_count_clear(sat_count_clear)
    );

    fixed_requant_stream #(
        .IN_WIDTH(16), .OUT_WIDTH(8), .SHIFT(4), .ROUND_MODE(ROUND_HALF_UP),
        .SYMMETRIC(1'b0), .CNT_WIDTH(2)
    ) dut_c2 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(in_rdy_c2), .data_out(dout_c2), .data_out_valid(dvld_c2),
        .data_out_ready(data_out_ready), .sat_count(sat_count_c2), .sat_count_clear(sat_count_clear)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Offer one sample; expected response is queued at the negedge before the accepting edge.
    task automatic send_chk(input int v, input int ed, input int es, input bit sd, input bit ss);
        exp_t e;
        bit ok = 1'b0;
        data_in       = 16'(v);
        data_in_valid = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (in_rdy) begin
                e = '{ed, es, sd, ss, cyc};
                q.push_back(e);
                ok = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        chk("send_accept", int'(ok), 1);
    endtask

    task automatic send_model(input int v);
        int r, ed, es;
        r  = (v + 8) >>> 4;
        ed = (r > 127) ? 127 : ((r < -128) ? -128 : r);
        es = (r > 127) ? 127 : ((r < -127) ? -127 : r);
        send_chk(v, ed, es, ed != r, es != r);
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && (q.size() != 0 || dvld); i++) @(negedge clk);
        @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("sat_count", int'(sat_count), cnt_def);
            chk("sat_count_sym", int'(sat_count_sym), cnt_sym);
            chk("sat_count_c2", int'(sat_count_c2), cnt_c2);
            if (hold_prev) begin
                chk("hold_valid", int'(dvld), 1);
                chk("hold_data", int'(dout), int'(prev_dat));
            end
            hold_prev = dvld && !data_out_ready && !rst;
            prev_dat  = dout;
            s_d = 1'b0;
            s_s = 1'b0;
            if (rst) begin
                q.delete();
                cnt_def = 0;
                cnt_sym = 0;
                cnt_c2  = 0;
            end else begin
                if (dvld && data_out_ready) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_out: got output %0d, expected none (t=%0t)", dout, $time);
                    end else begin
                        me = q.pop_front();
                        n_pop++;
                        chk("data_out", int'(dout), me.def);
                        chk("data_out_sym", int'(dout_sym), me.sym);
                        chk("data_out_c2", int'(dout_c2), me.def);
                        chk("valid_sym", int'(dvld_sym), 1);
                        chk("valid_c2", int'(dvld_c2), 1);
                        chk("in_ready_match", int'(in_rdy_sym) + int'(in_rdy_c2), 2 * int'(in_rdy));
                        if (lat_chk) chk("latency", cyc - me.cyc, 2);
                        s_d = me.sd;
                        s_s = me.ss;
                    end
                end
                if (sat_count_clear) begin
                    cnt_def = 0;
                    cnt_sym = 0;
                    cnt_c2  = 0;
                end else begin
                    if (s_d) begin
                        cnt_def++;
                        if (cnt_c2 < 3) cnt_c2++;
                    end
                    if (s_s) cnt_sym++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t dv[13];
        int   t0, n0;
        dv = '{
            '{24, 2, 2, 1'b0, 1'b0},
            '{23, 1, 1, 1'b0, 1'b0},
            '{-24, -1, -1, 1'b0, 1'b0},
            '{40, 3, 3, 1'b0, 1'b0},
            '{-40, -2, -2, 1'b0, 1'b0},
            '{2031, 127, 127, 1'b0, 1'b0},
            '{2032, 127, 127, 1'b0, 1'b0},
            '{2040, 127, 127, 1'b1, 1'b1},
            '{-2040, -127, -127, 1'b0, 1'b0},
            '{-2056, -128, -127, 1'b0, 1'b1},
            '{-2057, -128, -127, 1'b1, 1'b1},
            '{32767, 127, 127, 1'b1, 1'b1},
            '{-32768, -128, -127, 1'b1, 1'b1}
        };

        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", int'(dvld), 0);
        chk("rst_data_out", int'(dout), 0);
        chk("rst_sat_count", int'(sat_count), 0);
        chk("rst_in_ready", int'(in_rdy), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors, back-to-back, unstalled so latency is exact.
        lat_chk = 1'b1;
        foreach (dv[i]) send_chk(dv[i].v, dv[i].ed, dv[i].es, dv[i].sd, dv[i].ss);
        drain();
        lat_chk = 1'b0;
        chk("dir_sat_def", int'(sat_count), 4);
        chk("dir_sat_sym", int'(sat_count_sym), 5);
        chk("dir_sat_c2", int'(sat_count_c2), 3);

        t0 = cyc;
        for (int i = 0; i < 8; i++) send_model(int'($urandom_range(6000)) - 3000);
        chk("throughput_cycles", cyc - t0, 8);
        drain();

        // Stall: two samples fit in the pipeline, the third must wait.
        data_out_ready = 1'b0;
        t0 = cyc;
        send_chk(48, 3, 3, 1'b0, 1'b0);
        send_chk(64, 4, 4, 1'b0, 1'b0);
        chk("stall_two_accepted", cyc - t0, 2);
        data_in       = 16'(300);
        data_in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("stall_in_ready", int'(in_rdy), 0);
        end
        @(posedge clk);
        #1;
        data_out_ready = 1'b1;
        send_chk(300, 19, 19, 1'b0, 1'b0);
        drain();

        // Clear coinciding with a saturated output transfer.
        data_out_ready = 1'b0;
        send_chk(32767, 127, 127, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("clr_out_pending", int'(dvld), 1);
        @(posedge clk);
        #1;
        data_out_ready  = 1'b1;
        sat_count_clear = 1'b1;
        @(posedge clk);
        #1;
        sat_count_clear = 1'b0;
        @(negedge clk);
        chk("clr_priority", int'(sat_count), 0);
        chk("clr_priority_c2", int'(sat_count_c2), 0);
        drain();

        repeat (5) send_chk(32767, 127, 127, 1'b1, 1'b1);
        drain();
        chk("c2_sticky_max", int'(sat_count_c2), 3);
        chk("c2_def_count", int'(sat_count), 5);

        // Random stream under random downstream backpressure.
        n0      = n_pop;
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send_model(int'($urandom_range(6000)) - 3000);
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    if (rand_on) data_out_ready = 1'($urandom_range(1));
                end
            end
        join
        data_out_ready = 1'b1;
        drain();
        chk("rand_delivered", n_pop - n0, 100);

        // Reset with both stages full flushes everything.
        data_out_ready = 1'b0;
        send_chk(100, 6, 6, 1'b0, 1'b0);
        send_chk(200, 13, 13, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_before_rst", int'(dvld), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_flush_valid", int'(dvld), 0);
        chk("rst_flush_sat", int'(sat_count), 0);
        chk("rst_flush_in_ready", int'(in_rdy), 1);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        data_out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_rdy), 1);
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_no_output", int'(dvld), 0);
        end
        @(posedge clk);
        #1;
        send_chk(24, 2, 2, 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_requant_stream.md
FIXED_REQUANT_STREAM -- requirements
Module: fixed_requant_stream

Interface
REQ-001 Parameter IN_WIDTH, default 16: signed input sample width in bits.
REQ-002 Parameter OUT_WIDTH, default 8: signed output sample width; must be less than or equal to IN_WIDTH.
REQ-003 Parameter SHIFT, default 4: fractional bits dropped; legal range 0..IN_WIDTH-1.
REQ-004 Parameter ROUND_MODE, default ROUND_HALF_UP: ROUND_FLOOR truncates; ROUND_HALF_UP adds half an LSB, then shifts.
REQ-005 Parameter SYMMETRIC, default 0: 1 sets the saturation minimum to -(2^(OUT_WIDTH-1))+1.
REQ-006 Parameter CNT_WIDTH, default 16: saturation counter width.
REQ-007 clk  input  1  rising-edge clock; the block has one clock; reset is synchronous and active-high.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 data_in  input  IN_WIDTH  signed sample.
REQ-010 data_in_valid  input  1  upstream sample valid.
REQ-011 data_in_ready  output  1  block accepts a sample this cycle.
REQ-012 data_out  output  OUT_WIDTH  signed requantized sample.
REQ-013 data_out_valid  output  1  output sample valid.
REQ-014 data_out_ready  input  1  downstream accepts.
REQ-015 sat_count  output  CNT_WIDTH  number of saturated samples delivered.
REQ-016 sat_count_clear  input  1  synchronous clear of sat_count.

Function
REQ-017 Transfer occurs on any edge where valid and ready are both high; no sample is dropped or duplicated.
REQ-018 Two-stage pipeline; stage 1 registers the rounded and shifted value; stage 2 registers the clamped value; latency is exactly 2 cycles from input transfer to data_out_valid when unstalled.
REQ-019 Throughput is 1 sample per cycle when data_out_ready stays high.
REQ-020 Stage 2 loads when it is empty or data_out_ready is high; stage 1 loads when it is empty or stage 2 loads.
REQ-021 data_in_ready = !s1_valid || stage-2-load; this path is combinational from data_out_ready.
REQ-022 Rounding is computed at IN_WIDTH+1 bits to prevent overflow. ROUND_HALF_UP adds 2^(SHIFT-1) before an arithmetic right shift by SHIFT. ROUND_FLOOR uses an arithmetic shift only.
REQ-023 SHIFT=0 bypasses rounding; the value passes to the clamp unchanged.
REQ-024 Clamp limits: MAX = 2^(OUT_WIDTH-1)-1; MIN = -(2^(OUT_WIDTH-1)), or MIN+1 when SYMMETRIC=1. In-range values pass unchanged.
REQ-025 Stage 2 carries a sat flag, set when the clamp altered the value.
REQ-026 sat_count increments by 1 on each output transfer whose sat flag is set.
REQ-027 sat_count holds at all-ones and does not wrap.
REQ-028 sat_count_clear forces sat_count to 0 on the next edge; clear has priority over a simultaneous increment.
REQ-029 While data_out_valid is high and data_out_ready is low, data_out and data_out_valid shall hold stable.

Reset
REQ-030 On rst, s1_valid, data_out_valid, data_out, internal data registers and sat_count shall all be 0.
REQ-031 Reset mid-stream discards all in-flight samples. data_in_ready shall be high in the first cycle after rst deasserts.
REQ-032 rst has priority over every other input.

Structure
REQ-033 The round-mode enum (ROUND_FLOOR=0, ROUND_HALF_UP=1) lives in shared package cast_pkg.
REQ-034 Stage-2 saturation is a single instance of the existing signed_clamp sub-module; no other sub-modules are used.

Verification
REQ-035 Test parameters are defaults (16 to 8, SHIFT=4, HALF_UP). Inputs 24, 23 and -24 shall produce outputs 2, 1 and -1 respectively, each 2 cycles later, with sat_count staying at 0.
REQ-036 Input 32767 shall produce 127 and sat_count 1. Input -32768 shall produce -128 when SYMMETRIC=0 and -127 when SYMMETRIC=1; sat_count increments each time.
REQ-037 Streaming 100 random samples while data_out_ready toggles randomly shall deliver all 100 in order, with no loss or duplicate, matching the reference model.
REQ-038 Holding data_out_ready low with 3 samples offered shall accept exactly 2, then drop data_in_ready low, with data_out held stable until ready rises.
REQ-039 sat_count_clear asserted in the same cycle as a saturated output transfer shall leave sat_count at 0. With CNT_WIDTH=2, 5 saturated transfers shall hold sat_count at 3.
REQ-040 Asserting rst with both stages full shall give data_out_valid 0, sat_count 0 and data_in_ready 1 on the next cycle; the flushed samples shall never appear.
